// File: rtl/lenet_pkg.sv
// Shared types and per-layer constant tables for the LeNet-5 layer sequencer.
package lenet_pkg;

   localparam int LAYER_COUNT = 7;

   typedef enum logic [2:0] {
      L_CONV1 = 3'd0,
      L_POOL1 = 3'd1,
      L_CONV2 = 3'd2,
      L_POOL2 = 3'd3,
      L_FC1   = 3'd4,
      L_FC2   = 3'd5,
      L_FC3   = 3'd6
   } layer_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG,
      S_KICK,
      S_WAIT,
      S_NEXT,
      S_FIN
   } seq_state_e;

   localparam logic [1:0] RD_IMG   = 2'd0;
   localparam logic [1:0] RD_BUF_A = 2'd1;
   localparam logic [1:0] RD_BUF_B = 2'd2;
   localparam logic       WR_BUF_A = 1'b0;
   localparam logic       WR_BUF_B = 1'b1;

   typedef struct packed {
      logic [4:0]  in_ch;
      logic [4:0]  out_ch;
      logic [8:0]  in_dim;
      logic [8:0]  out_dim;
      logic [15:0] w_base;
      logic [7:0]  b_base;
   } layer_cfg_t;

   // Weight/bias bases are cumulative offsets; pool layers own no parameters.
   function automatic layer_cfg_t layer_cfg(input logic [2:0] idx);
      layer_cfg_t c;
      case (layer_e'(idx))
         L_POOL1: c = '{5'd6,  5'd6,  9'd28,  9'd14,  16'd0,     8'd0};
         L_CONV2: c = '{5'd6,  5'd16, 9'd14,  9'd10,  16'd150,   8'd6};
         L_POOL2: c = '{5'd16, 5'd16, 9'd10,  9'd5,   16'd0,     8'd0};
         L_FC1:   c = '{5'd16, 5'd1,  9'd400, 9'd120, 16'd2550,  8'd22};
         L_FC2:   c = '{5'd1,  5'd1,  9'd120, 9'd84,  16'd50550, 8'd142};
         L_FC3:   c = '{5'd1,  5'd1,  9'd84,  9'd10,  16'd60630, 8'd226};
         default: c = '{5'd1,  5'd6,  9'd32,  9'd28,  16'd0,     8'd0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lenet_layer_cfg_rom.sv
// Combinational layer index -> layer configuration lookup.
module lenet_layer_cfg_rom
   import lenet_pkg::*;
(
   input  logic [2:0]  layer,
   output logic [4:0]  in_ch,
   output logic [4:0]  out_ch,
   output logic [8:0]  in_dim,
   output logic [8:0]  out_dim,
   output logic [15:0] w_base,
   output logic [7:0]  b_base
);

   layer_cfg_t cfg;

   assign cfg     = layer_cfg(layer);
   assign in_ch   = cfg.in_ch;
   assign out_ch  = cfg.out_ch;
   assign in_dim  = cfg.in_dim;
   assign out_dim = cfg.out_dim;
   assign w_base  = cfg.w_base;
   assign b_base  = cfg.b_base;

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Steps the shared LeNet-5 engines through CONV1..FC3 with a per-layer watchdog.
// Optional per-layer WAIT cycle counters are built when LAYER_PERF_EN is defined.
module lenet_layer_sequencer
   import lenet_pkg::*;
#(
   parameter int NUM_LAYERS     = 7,
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int CNT_W          = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2:0]       err_layer,
   output logic [2:0]       eng_sel,
   output logic             eng_start,
   input  logic             eng_done,
   output logic [1:0]       rd_src,
   output logic             wr_dst,
   output logic [4:0]       cfg_in_ch,
   output logic [4:0]       cfg_out_ch,
   output logic [8:0]       cfg_in_dim,
   output logic [8:0]       cfg_out_dim,
   output logic [15:0]      cfg_w_base,
   output logic [7:0]       cfg_b_base,
   input  logic [2:0]       perf_idx,
   output logic [CNT_W-1:0] perf_cycles
);

   localparam logic [2:0]       LAST_LAYER = 3'(NUM_LAYERS - 1);
   localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_e       state_q, state_d;
   logic [2:0]       layer_q, layer_d;
   logic [CNT_W-1:0] wdog_q;
   logic             err_q;
   logic [2:0]       err_layer_q;
   logic [2:0]       eng_sel_q;
   logic [1:0]       rd_src_q;
   logic             wr_dst_q;
   layer_cfg_t       cfg_q, rom_cfg;
   logic             accept, timeout;

   lenet_layer_cfg_rom u_cfg_rom (
      .layer   (layer_q),
      .in_ch   (rom_cfg.in_ch),
      .out_ch  (rom_cfg.out_ch),
      .in_dim  (rom_cfg.in_dim),
      .out_dim (rom_cfg.out_dim),
      .w_base  (rom_cfg.w_base),
      .b_base  (rom_cfg.b_base)
   );

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      layer_d   = layer_q;
      accept    = 1'b0;
      timeout   = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FIN);
      eng_start = (state_q == S_KICK);
      case (state_q)
         S_IDLE: if (start) begin
            accept  = 1'b1;
            layer_d = 3'd0;
            state_d = S_CFG;
         end
         S_CFG:  state_d = S_KICK;
         S_KICK: state_d = S_WAIT;
         // eng_done takes priority over a watchdog expiry in the same cycle.
         S_WAIT: if (eng_done) begin
            state_d = S_NEXT;
         end else if (wdog_q == WDOG_LAST) begin
            timeout = 1'b1;
            state_d = S_FIN;
         end
         S_NEXT: if (layer_q == LAST_LAYER) begin
            state_d = S_FIN;
         end else begin
            layer_d = layer_q + 3'd1;
            state_d = S_CFG;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous to clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         layer_q     <= 3'd0;
         wdog_q      <= '0;
         err_q       <= 1'b0;
         err_layer_q <= 3'd0;
         eng_sel_q   <= 3'd0;
         rd_src_q    <= RD_IMG;
         wr_dst_q    <= WR_BUF_A;
         cfg_q       <= layer_cfg(L_CONV1);
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         if (accept) err_q <= 1'b0;
         if (timeout) begin
            err_q       <= 1'b1;
            err_layer_q <= layer_q;
         end
         if (state_q == S_CFG) begin
            wdog_q    <= '0;
            eng_sel_q <= layer_q;
            cfg_q     <= rom_cfg;
            wr_dst_q  <= layer_q[0];
            // Each layer reads whichever buffer the previous layer wrote.
            if (layer_q == 3'd0)  rd_src_q <= RD_IMG;
            else if (layer_q[0])  rd_src_q <= RD_BUF_A;
            else                  rd_src_q <= RD_BUF_B;
         end else if (state_q == S_WAIT) begin
            wdog_q <= wdog_q + 1'b1;
         end
      end
   end

   assign err         = err_q;
   assign err_layer   = err_layer_q;
   assign eng_sel     = eng_sel_q;
   assign rd_src      = rd_src_q;
   assign wr_dst      = wr_dst_q;
   assign cfg_in_ch   = cfg_q.in_ch;
   assign cfg_out_ch  = cfg_q.out_ch;
   assign cfg_in_dim  = cfg_q.in_dim;
   assign cfg_out_dim = cfg_q.out_dim;
   assign cfg_w_base  = cfg_q.w_base;
   assign cfg_b_base  = cfg_q.b_base;

`ifdef LAYER_PERF_EN
   logic [CNT_W-1:0] perf_cnt [NUM_LAYERS];
   logic [CNT_W-1:0] perf_q;

   // NOTE: the counter array is reset explicitly because its contents are software-visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LAYERS; i++) perf_cnt[i] <= '0;
         perf_q <= '0;
      end else begin
         if (accept) begin
            for (int i = 0; i < NUM_LAYERS; i++) perf_cnt[i] <= '0;
         end else if (state_q == S_WAIT && perf_cnt[layer_q] != '1) begin
            perf_cnt[layer_q] <= perf_cnt[layer_q] + 1'b1;
         end
         perf_q <= (perf_idx <= LAST_LAYER) ? perf_cnt[perf_idx] : '0;
      end
   end

   assign perf_cycles = perf_q;
`else
   logic unused_perf_idx;

   assign unused_perf_idx = ^perf_idx;
   assign perf_cycles     = '0;
`endif

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Self-checking bench: cycle-level schedule model of the sequencer plus literal spot checks.
module tb_lenet_layer_sequencer;

`ifdef LAYER_PERF_EN
   localparam int TO = 100;
`else
   localparam int TO = 50;
`endif
   localparam int NL = 7;
   localparam int CW = 24;

   logic          clk = 1'b0;
   logic          rst, start, eng_done;
   logic [2:0]    perf_idx;
   logic          busy, done, err, eng_start, wr_dst;
   logic [2:0]    err_layer, eng_sel;
   logic [1:0]    rd_src;
   logic [4:0]    cfg_in_ch, cfg_out_ch;
   logic [8:0]    cfg_in_dim, cfg_out_dim;
   logic [15:0]   cfg_w_base;
   logic [7:0]    cfg_b_base;
   logic [CW-1:0] perf_cycles;

   lenet_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .err_layer(err_layer), .eng_sel(eng_sel), .eng_start(eng_start), .eng_done(eng_done),
      .rd_src(rd_src), .wr_dst(wr_dst), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
      .cfg_in_dim(cfg_in_dim), .cfg_out_dim(cfg_out_dim), .cfg_w_base(cfg_w_base),
      .cfg_b_base(cfg_b_base), .perf_idx(perf_idx), .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   int t_in_ch  [NL] = '{1, 6, 6, 16, 16, 1, 1};
   int t_out_ch [NL] = '{6, 6, 16, 16, 1, 1, 1};
   int t_in_dim [NL] = '{32, 28, 14, 10, 400, 120, 84};
   int t_out_dim[NL] = '{28, 14, 10, 5, 120, 84, 10};
   int t_w      [NL] = '{0, 0, 150, 0, 2550, 50550, 60630};
   int t_b      [NL] = '{0, 0, 6, 0, 22, 142, 226};

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Responder latency per layer (-1 = never answers); eng_done rises lat cycles
   // after the clock edge that captures eng_start.
   int lat_tab[NL];
   int due_q[$];

   int ev_sel[$], ev_rd[$], ev_wr[$];
   int done_cnt = 0;
   int last_kick = 0;
   int c2_cfg[6];

   // Model state: schedule of the current run in absolute cycle numbers.
   bit m_valid = 0, m_active = 0, m_waiting = 0, m_err = 0;
   int m_layer = 0, m_cfg_layer = 0, m_err_layer = 0, m_kick = -1, m_fin = -1;
   int m_cnt[NL];
   int m_perf_next = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      eng_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         eng_done = 1'b0;
         for (int i = due_q.size() - 1; i >= 0; i--) begin
            if (due_q[i] <= cyc) begin
               if (due_q[i] == cyc) eng_done = 1'b1;
               due_q.delete(i);
            end
         end
      end
   end

   // Compare, log, respond, then advance the model by one clock edge.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         int wr, rd, pexp;
         wr   = m_cfg_layer % 2;
         rd   = (m_cfg_layer == 0) ? 0 : ((wr == 1) ? 1 : 2);
`ifdef LAYER_PERF_EN
         pexp = m_perf_next;
`else
         pexp = 0;
`endif
         check("busy",        busy,        m_active);
         check("done",        done,        m_active && cyc == m_fin);
         check("eng_start",   eng_start,   m_active && cyc == m_kick);
         check("err",         err,         m_err);
         check("err_layer",   err_layer,   m_err_layer);
         check("eng_sel",     eng_sel,     m_cfg_layer);
         check("rd_src",      rd_src,      rd);
         check("wr_dst",      wr_dst,      wr);
         check("cfg_in_ch",   cfg_in_ch,   t_in_ch[m_cfg_layer]);
         check("cfg_out_ch",  cfg_out_ch,  t_out_ch[m_cfg_layer]);
         check("cfg_in_dim",  cfg_in_dim,  t_in_dim[m_cfg_layer]);
         check("cfg_out_dim", cfg_out_dim, t_out_dim[m_cfg_layer]);
         check("cfg_w_base",  cfg_w_base,  t_w[m_cfg_layer]);
         check("cfg_b_base",  cfg_b_base,  t_b[m_cfg_layer]);
         check("perf_cycles", perf_cycles, pexp);
      end

      if (done === 1'b1) done_cnt++;
      if (eng_start === 1'b1) begin
         last_kick = cyc;
         ev_sel.push_back(int'(eng_sel));
         ev_rd.push_back(int'(rd_src));
         ev_wr.push_back(int'(wr_dst));
         if (eng_sel == 3'd2)
            c2_cfg = '{int'(cfg_in_ch), int'(cfg_out_ch), int'(cfg_in_dim),
                       int'(cfg_out_dim), int'(cfg_w_base), int'(cfg_b_base)};
         if (int'(eng_sel) < NL && lat_tab[eng_sel] >= 0)
            due_q.push_back(cyc + 1 + lat_tab[eng_sel]);
      end

      if (rst) begin
         m_valid = 1; m_active = 0; m_waiting = 0; m_err = 0;
         m_cfg_layer = 0; m_err_layer = 0; m_kick = -1; m_fin = -1; m_perf_next = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (m_valid) begin
         m_perf_next = (int'(perf_idx) < NL) ? m_cnt[perf_idx] : 0;
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_layer = 0; m_err = 0; m_waiting = 0;
               m_kick = cyc + 2; m_fin = -1;
               foreach (m_cnt[i]) m_cnt[i] = 0;
            end
         end else if (cyc == m_fin) begin
            m_active = 0;
         end else if (cyc == m_kick - 1) begin
            m_cfg_layer = m_layer;
         end else if (cyc == m_kick) begin
            m_waiting = 1;
         end else if (m_waiting) begin
            if (m_cnt[m_layer] < (1 << CW) - 1) m_cnt[m_layer]++;
            if (eng_done) begin
               m_waiting = 0;
               if (m_layer == NL - 1) m_fin = cyc + 2;
               else begin
                  m_layer++;
                  m_kick = cyc + 3;
               end
            end else if (cyc - m_kick - 1 == TO - 1) begin
               m_waiting = 0; m_err = 1; m_err_layer = m_layer; m_fin = cyc + 1;
            end
         end
      end
   end

   task automatic clear_log();
      ev_sel.delete(); ev_rd.delete(); ev_wr.delete();
      done_cnt = 0;
   endtask

   task automatic set_lat(input int l);
      foreach (lat_tab[i]) lat_tab[i] = l;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Waits for a done pulse; optionally jitters perf_idx and injects spurious inputs.
   task automatic wait_done(input string name, input bit jitter);
      int n0;
      bit seen;
      n0   = done_cnt;
      seen = 0;
      for (int i = 0; i < NL * (TO + 80) + 100 && !seen; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (jitter) begin
            perf_idx = 3'($urandom_range(0, NL - 1));
            if ($urandom_range(0, 29) == 0) due_q.push_back(cyc + 1);
            if ($urandom_range(0, 39) == 0) start = 1'b1;
         end
         seen = (done_cnt != n0);
      end
      start = 1'b0;
      check(name, seen, 1'b1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   int exp_rd[NL] = '{0, 1, 2, 1, 2, 1, 2};

   task automatic check_full_seq(input string tag);
      check({tag, "_starts"}, ev_sel.size(), NL);
      for (int k = 0; k < NL && k < ev_sel.size(); k++) begin
         check({tag, "_sel"}, ev_sel[k], k);
         check({tag, "_rd"},  ev_rd[k],  exp_rd[k]);
         check({tag, "_wr"},  ev_wr[k],  k % 2);
      end
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; perf_idx = 3'd0;
      set_lat(10);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_eng_sel", eng_sel, 0);
      check("rst_in_dim", cfg_in_dim, 32);
      check("rst_out_ch", cfg_out_ch, 6);
      check("rst_perf", perf_cycles, 0);

      // Normal run, then CONV2 configuration pinned literally.
      clear_log();
      pulse_start();
      wait_done("normal_end", 0);
      check_full_seq("normal");
      check("c2_in_ch",   c2_cfg[0], 6);
      check("c2_out_ch",  c2_cfg[1], 16);
      check("c2_in_dim",  c2_cfg[2], 14);
      check("c2_out_dim", c2_cfg[3], 10);
      check("c2_w_base",  c2_cfg[4], 150);
      check("c2_b_base",  c2_cfg[5], 6);

      // Timeout on POOL2.
      lat_tab[3] = -1;
      clear_log();
      pulse_start();
      wait_done("timeout_end", 0);
      check("to_err", err, 1);
      check("to_err_layer", err_layer, 3);
      check("to_starts", ev_sel.size(), 4);
      check("to_done_cnt", done_cnt, 1);

      // Race on expiry cycle, spurious start while busy; err cleared by the new start.
      set_lat(10);
      lat_tab[2] = TO - 1;
      clear_log();
      pulse_start();
      repeat (6) @(posedge clk);
      pulse_start();
      wait_done("race_end", 0);
      check_full_seq("race");

      // Spurious eng_done in IDLE.
      @(posedge clk); #1;
      due_q.push_back(cyc + 1);
      due_q.push_back(cyc + 3);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("spur_idle_busy", busy, 0);
      check("spur_idle_sel", eng_sel, 6);

      // Reset in cycle 5 of the FC1 wait.
      set_lat(10);
      lat_tab[4] = -1;
      clear_log();
      pulse_start();
      for (int i = 0; i < 2000 && ev_sel.size() < 5; i++) @(posedge clk);
      check("fc1_reached", ev_sel.size(), 5);
      do begin @(posedge clk); #1; end while (cyc < last_kick + 5);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sel", eng_sel, 0);
      check("mid_rst_rd", rd_src, 0);
      repeat (10) @(posedge clk);
      check("mid_rst_no_done", done_cnt, 0);
      set_lat(10);
      clear_log();
      pulse_start();
      wait_done("after_rst_end", 0);
      check_full_seq("after_rst");

`ifdef LAYER_PERF_EN
      foreach (lat_tab[k]) lat_tab[k] = 10 * (k + 1);
      clear_log();
      pulse_start();
      wait_done("perf_end", 0);
      for (int k = 0; k < NL; k++) begin
         @(posedge clk); #1 perf_idx = 3'(k);
         @(posedge clk);
         @(negedge clk);
         check("perf_lit", perf_cycles, 10 * (k + 1) + 1);
      end
`endif

      // Randomized runs: mixed latencies, occasional hangs, races and spurious inputs.
      for (int r = 0; r < 20; r++) begin
         foreach (lat_tab[k]) begin
            int sel;
            sel = $urandom_range(0, 19);
            lat_tab[k] = (sel == 0) ? -1 : (sel == 1) ? TO - 1 : $urandom_range(0, TO + 3);
         end
         pulse_start();
         wait_done("rand_end", 1);
      end

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
